// File: rtl/rot_arb_pkg.sv
// Shared constants and helpers for the rotate arbiter.
// The optional build macro ROT_ARB_FIXED_PRIO_EN is consumed by rot_arb_pick and rot_arbiter.
package rot_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ost_e;

  // Round-robin pointer wrap: the slot after the winner.
  function automatic int rr_next(input int ptr, input int num_req);
    return (ptr + 1 >= num_req) ? 0 : ptr + 1;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// 8-bit combinational rotate-right: result[i] = data[(i+shamt) mod 8].
module barrel_shifter (
  input  logic [7:0] data,
  input  logic [2:0] shamt,
  output logic [7:0] result
);

  always_comb begin
    result = data;
    if (shamt[0]) result = {result[0],   result[7:1]};
    if (shamt[1]) result = {result[1:0], result[7:2]};
    if (shamt[2]) result = {result[3:0], result[7:4]};
  end

endmodule

// File: rtl/rot_arb_pick.sv
// Grant selection: round-robin from ptr by default, or lowest-index fixed
// priority when ROT_ARB_FIXED_PRIO_EN is defined (no ptr port in that build).
module rot_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef ROT_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    ptr,
`endif
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner
);

`ifdef ROT_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    gnt    = '0;
    winner = '0;
    for (int r = NUM_REQ - 1; r >= 0; r--) begin
      if (req[r]) begin
        gnt    = '0;
        gnt[r] = 1'b1;
        winner = ID_W'(r);
      end
    end
  end
`else
  int best;

  // Smallest distance from ptr (modulo NUM_REQ) among valid requesters wins.
  always_comb begin
    gnt    = '0;
    winner = '0;
    best   = NUM_REQ;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (req[r] && ((r + NUM_REQ - int'(ptr)) % NUM_REQ) < best) begin
        best   = (r + NUM_REQ - int'(ptr)) % NUM_REQ;
        gnt    = '0;
        gnt[r] = 1'b1;
        winner = ID_W'(r);
      end
    end
  end
`endif

endmodule

// File: rtl/rot_arbiter.sv
// Shares one barrel_shifter among NUM_REQ requesters behind a one-entry output stage.
// Define ROT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rot_arbiter
  import rot_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  output logic [NUM_REQ-1:0]          o_req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  input  logic [NUM_REQ*SHAMT_W-1:0]  i_req_shamt,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_W-1:0]           o_data,
  output logic [ID_W-1:0]             o_id
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rot_arbiter: NUM_REQ must be 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("rot_arbiter: ID_W must equal $clog2(NUM_REQ)");
  end

  ost_e                st_q, st_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     winner;
  logic [DATA_W-1:0]   op, rot;
  logic [SHAMT_W-1:0]  sh;
  logic                can_accept, accept;
`ifndef ROT_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     ptr_q, ptr_d;
`endif

  rot_arb_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req    (i_req_valid),
`ifndef ROT_ARB_FIXED_PRIO_EN
    .ptr    (ptr_q),
`endif
    .gnt    (gnt),
    .winner (winner)
  );

  always_comb begin
    op = '0;
    sh = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gnt[r]) begin
        op = i_req_data[slice_lo(r, DATA_W) +: DATA_W];
        sh = i_req_shamt[slice_lo(r, SHAMT_W) +: SHAMT_W];
      end
    end
  end

  barrel_shifter u_bs (
    .data   (op),
    .shamt  (sh),
    .result (rot)
  );

  // Reset suppresses the handshake so a simultaneous accept is never acknowledged.
  always_comb begin
    can_accept  = (st_q == EMPTY) || i_ready;
    o_req_ready = gnt & {NUM_REQ{can_accept & ~i_rst}};
    accept      = |o_req_ready;
    st_d        = st_q;
    data_d      = data_q;
    id_d        = id_q;
`ifndef ROT_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (accept) begin
      st_d   = FULL;
      data_d = rot;
      id_d   = winner;
`ifndef ROT_ARB_FIXED_PRIO_EN
      ptr_d  = ID_W'(rr_next(int'(winner), NUM_REQ));
`endif
    end else if (st_q == FULL && i_ready) begin
      st_d = EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q   <= EMPTY;
      data_q <= '0;
      id_q   <= '0;
`ifndef ROT_ARB_FIXED_PRIO_EN
      ptr_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      data_q <= data_d;
      id_q   <= id_d;
`ifndef ROT_ARB_FIXED_PRIO_EN
      ptr_q  <= ptr_d;
`endif
    end
  end

  assign o_valid = (st_q == FULL);
  assign o_data  = data_q;
  assign o_id    = id_q;

endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Shares one combinational 8-bit barrel_shifter (rotate-right) among NUM_REQ requesters.
- Arbitrates among pending requests and launches one rotation per cycle.
- Registers the result with the winning requester's ID into a single-entry output stage with valid/ready backpressure.
- Sits between the per-channel producers and the downstream consumer of rotated bytes.

Parameters:
- NUM_REQ, 4, number of requesters; legal 2..8.
- ID_W, 2, width of requester ID; must equal $clog2(NUM_REQ); elaboration error otherwise.

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, synchronous, active-high
- i_req_valid  input  NUM_REQ  per-requester request valid
- o_req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- i_req_data  input  NUM_REQ*8  packed operands; requester r at [8r+7:8r]
- i_req_shamt  input  NUM_REQ*3  packed rotate amounts; requester r at [3r+2:3r]
- o_valid  output  1  result valid
- i_ready  input  1  downstream accept
- o_data  output  8  rotated result
- o_id  output  ID_W  index of requester that produced o_data

Behaviour:
- Rotation: o_data[i] = operand[(i+shamt) mod 8], i.e. rotate right by shamt. shamt=0 passes the operand through.
- Transfer rule: a transfer occurs when valid and ready are both high in the same cycle, on both sides.
- Output stage states:
  - EMPTY (o_valid=0).
  - FULL (o_valid=1).
- can_accept = EMPTY | (FULL & i_ready). This gives full throughput of one result per cycle with no bubble.
- Grant:
  - Computed combinationally from i_req_valid and the round-robin pointer ptr.
  - Winner = first r with i_req_valid[r]=1, searching ptr, ptr+1, ... mod NUM_REQ.
- o_req_ready[r] = can_accept & (winner==r) & i_req_valid[r]. o_req_ready never depends on i_req_data or i_req_shamt.
- On an accept:
  - o_data <= rotated winner operand.
  - o_id <= winner.
  - o_valid <= 1.
  - ptr <= (winner+1) mod NUM_REQ.
- FULL & i_ready & no request: o_valid <= 0. o_data and o_id hold their last values.
- FULL & !i_ready: o_valid, o_data and o_id are held stable. All o_req_ready=0. ptr is unchanged.
- ptr advances only on an accepted grant. An unserved requester waits at most NUM_REQ-1 accepts.
- Latency: request accepted in cycle N gives o_valid=1 with that result in cycle N+1.
- Requester protocol: a requester that drops i_req_valid before being accepted is legal. It loses its turn without disturbing ptr.
- Reset (i_rst=1 at an edge):
  - o_valid=0, o_data=8'h00, o_id=0, ptr=0.
  - o_req_ready=0 throughout the reset cycle.
  - Any result held mid-operation is discarded.
  - Reset overrides a simultaneous accept.
- No X propagation: o_data and o_id are always driven from registers.

Optional Feature:
- Macro: ROT_ARB_FIXED_PRIO_EN.
- Defined: winner = lowest-index valid requester, and ptr is removed. Requester 0 can starve the others; this is the intended behaviour.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

Decomposition:
- Package rot_arb_pkg holds:
  - localparam DATA_W=8 and SHAMT_W=3.
  - Function rr_next(ptr, NUM_REQ) for the pointer wrap.
  - Helper function for the packed-slice index.
- One sub-module: rot_arb_pick. It takes the request vector and ptr and outputs a one-hot grant and a binary winner. It has two bodies selected by ROT_ARB_FIXED_PRIO_EN.
- The existing 8-bit barrel_shifter is instantiated unchanged as the datapath after a NUM_REQ:1 operand/shamt mux.

Test Plan:
- Reset then single request: req0 data=8'h81 shamt=1, i_ready=1 → next cycle o_valid=1, o_data=8'hC0, o_id=0; ptr moves to 1.
- All four requesters valid continuously, i_ready=1: req2 data=8'hB4 shamt=4 → 8'h4B when served; o_id sequence 0,1,2,3,0; one result per cycle, no gaps.
- Backpressure: result held with i_ready=0 for 3 cycles → o_data/o_id stable, o_req_ready=0 for all requesters; i_ready=1 → next winner accepted in the same cycle.
- Mid-operation reset: FULL with o_data=8'h20 (data 8'h01, shamt=3), assert i_rst for one cycle → o_valid=0, o_data=8'h00, ptr=0; next grant goes to the lowest valid index.
- Withdrawal: req1 valid while blocked by backpressure, then dropped before accept → no result with o_id=1 is produced and ptr is unchanged.
- With ROT_ARB_FIXED_PRIO_EN defined, req0 and req3 held valid → o_id=0 every cycle and req3 is never granted.
